// File: rtl/operand_load_seq.sv
// Load-button sequencer: turns presses into one-cycle enables for the A, B and
// R operand registers, with a programmable settle gap before the R capture.
module operand_load_seq #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_load,
    input  logic       clear,
    output logic       en_a,
    output logic       en_b,
    output logic       en_r,
    output logic [1:0] phase,
    output logic       done
);

    localparam logic [1:0] S_WAIT_A = 2'b00;
    localparam logic [1:0] S_WAIT_B = 2'b01;
    localparam logic [1:0] S_SETTLE = 2'b10;
    localparam logic [1:0] S_SHOW   = 2'b11;
    localparam logic [3:0] SETTLE_LOAD = 4'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES > 32'd15) begin : g_bad_wait
            $error("operand_load_seq: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    logic       r_btn_q;
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_en_a;
    logic       r_en_b;
    logic       r_en_r;
    logic       r_done;

    logic       w_rise;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_en_a_nxt;
    logic       w_en_b_nxt;
    logic       w_en_r_nxt;
    logic       w_done_nxt;

    // btn_q resets high so a button held through reset is not seen as a press
    assign w_rise = btn_load & ~r_btn_q;

    // Next-state, counter and enable decode; clear overrides any press
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_a_nxt  = 1'b0;
        w_en_b_nxt  = 1'b0;
        w_en_r_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = S_WAIT_A;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    if (w_rise) begin
                        w_en_a_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_B;
                    end else begin
                        w_state_nxt = S_WAIT_A;
                    end
                end
                S_WAIT_B: begin
                    if (w_rise) begin
                        w_en_b_nxt  = 1'b1;
                        w_cnt_nxt   = SETTLE_LOAD;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_WAIT_B;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_en_r_nxt  = 1'b1;
                        w_state_nxt = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_rise) begin
                        w_state_nxt = S_WAIT_A;
                    end else begin
                        w_state_nxt = S_SHOW;
                    end
                end
                default: begin
                    w_state_nxt = S_WAIT_A;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
        // done rises one cycle after entering SHOW (after the R capture edge)
        w_done_nxt = (r_state == S_SHOW) && (w_state_nxt == S_SHOW);
    end

    // State, counter, edge-detect and registered output updates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_q <= 1'b1;
            r_state <= S_WAIT_A;
            r_cnt   <= 4'd0;
            r_en_a  <= 1'b0;
            r_en_b  <= 1'b0;
            r_en_r  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_btn_q <= btn_load;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en_a  <= w_en_a_nxt;
            r_en_b  <= w_en_b_nxt;
            r_en_r  <= w_en_r_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign en_a  = r_en_a;
    assign en_b  = r_en_b;
    assign en_r  = r_en_r;
    assign phase = r_state;
    assign done  = r_done;

endmodule
